// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, data width
// and the sub-word store FSM state type.
package lsu_pkg;

   localparam int unsigned XLEN = 32;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RMW  = 1'b1
   } lsu_state_e;

endpackage

// File: rtl/lsu_byte_lane.sv
// Combinational lane logic: extracts and extends a load result from a memory
// word, and merges a byte/halfword store lane into a memory word.
module lsu_byte_lane
   import lsu_pkg::*;
(
   input  logic [2:0]      funct3,
   input  logic [1:0]      byte_off,
   input  logic [XLEN-1:0] mem_word,
   input  logic [XLEN-1:0] store_data,
   output logic [XLEN-1:0] load_data_c,
   output logic [XLEN-1:0] merged_c
);

   logic [4:0]      lane_shift;
   logic [XLEN-1:0] lane_word;
   logic [XLEN-1:0] lane_mask;

   always_comb begin
      lane_shift = {byte_off, 3'b000};
      lane_word  = mem_word >> lane_shift;

      unique case (funct3)
         F3_B:    load_data_c = {{24{lane_word[7]}}, lane_word[7:0]};
         F3_BU:   load_data_c = {24'h000000, lane_word[7:0]};
         F3_H:    load_data_c = {{16{lane_word[15]}}, lane_word[15:0]};
         F3_HU:   load_data_c = {16'h0000, lane_word[15:0]};
         default: load_data_c = lane_word;
      endcase

      // Only SB/SH reach the merge path, so funct3[0] alone picks the lane width.
      lane_mask = funct3[0] ? 32'h0000_FFFF : 32'h0000_00FF;
      merged_c  = (mem_word & ~(lane_mask << lane_shift))
                | ((store_data & lane_mask) << lane_shift);
   end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: single-cycle loads and word stores, two-cycle
// read-modify-write for byte/halfword stores, with fault detection.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int unsigned MEM_WORDS = 32
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_req,
   input  logic            i_we,
   input  logic [2:0]      i_funct3,
   input  logic [XLEN-1:0] i_addr,
   input  logic [XLEN-1:0] i_wdata,
   output logic            o_stall,
   output logic            o_rvalid,
   output logic [XLEN-1:0] o_rdata,
   output logic            o_fault,
   output logic            o_mem_we,
   output logic [XLEN-1:0] o_mem_addr,
   output logic [XLEN-1:0] o_mem_wdata,
   input  logic [XLEN-1:0] i_mem_rdata
);

   lsu_state_e      state_q, state_d;
   logic [XLEN-1:0] rdata_q, rdata_d;
   logic            rvalid_q, rvalid_d;
   logic            fault_q, fault_d;
   logic [XLEN-1:0] merged_q, merged_d;
   logic [XLEN-1:0] idx_q, idx_d;

   logic [XLEN-1:0] word_idx;
   logic [XLEN-1:0] load_data_c;
   logic [XLEN-1:0] merged_c;
   logic            legal_f3;
   logic            misaligned;
   logic            out_of_range;
   logic            bad_req;

   lsu_byte_lane u_byte_lane (
      .funct3      (i_funct3),
      .byte_off    (i_addr[1:0]),
      .mem_word    (i_mem_rdata),
      .store_data  (i_wdata),
      .load_data_c (load_data_c),
      .merged_c    (merged_c)
   );

   // Request decode: legality, alignment and address range.
   always_comb begin
      word_idx     = {2'b00, i_addr[XLEN-1:2]};
      legal_f3     = i_we ? (i_funct3 inside {F3_B, F3_H, F3_W})
                          : (i_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
      misaligned   = ((i_funct3[1:0] == 2'b01) && i_addr[0])
                  || ((i_funct3[1:0] == 2'b10) && (i_addr[1:0] != 2'b00));
      out_of_range = word_idx >= XLEN'(MEM_WORDS);
      bad_req      = !legal_f3 || misaligned || out_of_range;
   end

   always_comb begin
      state_d     = state_q;
      rdata_d     = rdata_q;
      rvalid_d    = 1'b0;
      fault_d     = 1'b0;
      merged_d    = merged_q;
      idx_d       = idx_q;
      o_stall     = 1'b0;
      o_mem_we    = 1'b0;
      o_mem_addr  = word_idx;
      o_mem_wdata = i_wdata;

      unique case (state_q)
         ST_IDLE: begin
            if (i_req) begin
               if (bad_req) begin
                  fault_d = 1'b1;
               end else if (!i_we) begin
                  rvalid_d = 1'b1;
                  rdata_d  = load_data_c;
               end else if (i_funct3 == F3_W) begin
                  o_mem_we = 1'b1;
               end else begin
                  o_stall  = 1'b1;
                  merged_d = merged_c;
                  idx_d    = word_idx;
                  state_d  = ST_RMW;
               end
            end
         end
         ST_RMW: begin
            // The held request is the same instruction; commit the merged word.
            o_mem_we    = 1'b1;
            o_mem_addr  = idx_q;
            o_mem_wdata = merged_q;
            state_d     = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      if (i_rst) begin
         o_mem_we = 1'b0;
         o_stall  = 1'b0;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q  <= ST_IDLE;
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
         fault_q  <= 1'b0;
         merged_q <= '0;
         idx_q    <= '0;
      end else begin
         state_q  <= state_d;
         rdata_q  <= rdata_d;
         rvalid_q <= rvalid_d;
         fault_q  <= fault_d;
         merged_q <= merged_d;
         idx_q    <= idx_d;
      end
   end

   assign o_rdata  = rdata_q;
   assign o_rvalid = rvalid_q;
   assign o_fault  = fault_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios plus random requests checked
// against a byte-addressed reference memory model.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        i_rst = 1'b1;
   logic        i_req = 1'b0;
   logic        i_we = 1'b0;
   logic [2:0]  i_funct3 = 3'b000;
   logic [31:0] i_addr = 32'h0;
   logic [31:0] i_wdata = 32'h0;
   logic        o_stall, o_rvalid, o_fault, o_mem_we;
   logic [31:0] o_rdata, o_mem_addr, o_mem_wdata, i_mem_rdata;

   logic [31:0] mem [32] = '{default: 32'h0};
   logic [31:0] ref_mem [32] = '{default: 32'h0};
   logic [31:0] snap [32];
   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   load_store_unit #(.MEM_WORDS(32)) dut (
      .i_clk(clk), .i_rst(i_rst), .i_req(i_req), .i_we(i_we),
      .i_funct3(i_funct3), .i_addr(i_addr), .i_wdata(i_wdata),
      .o_stall(o_stall), .o_rvalid(o_rvalid), .o_rdata(o_rdata),
      .o_fault(o_fault), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
      .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata)
   );

   // Downstream data memory: async read, write on the rising edge.
   assign i_mem_rdata = (o_mem_addr < 32) ? mem[o_mem_addr[4:0]] : 32'h0;
   always @(posedge clk) if (o_mem_we && o_mem_addr < 32) mem[o_mem_addr[4:0]] <= o_mem_wdata;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int unsigned size_of(input logic [2:0] f3);
      return 1 << (f3 % 4);
   endfunction

   function automatic bit ref_fault(input bit we, input logic [2:0] f3, input logic [31:0] addr);
      bit legal = we ? (f3 <= 2) : (f3 <= 2 || f3 == 4 || f3 == 5);
      if (!legal) return 1;
      if (addr % size_of(f3) != 0) return 1;
      return (addr / 4) >= 32;
   endfunction

   function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr);
      logic [31:0] v = ref_mem[int'(addr / 4)] >> (8 * (addr % 4));
      case (f3)
         3'd0: begin v = v % 256;   if (v >= 128)   v = v | 32'hFFFF_FF00; end
         3'd4: v = v % 256;
         3'd1: begin v = v % 65536; if (v >= 32768) v = v | 32'hFFFF_0000; end
         3'd5: v = v % 65536;
         default: ;
      endcase
      return v;
   endfunction

   function automatic logic [31:0] ref_store(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] wdata);
      logic [31:0] old = ref_mem[int'(addr / 4)];
      logic [31:0] mask;
      int unsigned sh = 8 * (addr % 4);
      if (size_of(f3) == 4) return wdata;
      mask = (32'h1 << (8 * size_of(f3))) - 32'h1;
      return (old & ~(mask << sh)) | ((wdata & mask) << sh);
   endfunction

   task automatic run_op(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata);
      bit flt = ref_fault(we, f3, addr);
      bit ld  = !we && !flt;
      bit sub = we && !flt && f3 != 3'd2;
      logic [31:0] exp_rd = 32'h0;
      logic [31:0] exp_wr = 32'h0;
      if (ld) exp_rd = ref_load(f3, addr);
      if (we && !flt) begin
         exp_wr = ref_store(f3, addr, wdata);
         ref_mem[int'(addr / 4)] = exp_wr;
      end
      @(negedge clk);
      i_req = 1'b1; i_we = we; i_funct3 = f3; i_addr = addr; i_wdata = wdata;
      #1;
      chk("req_stall", 32'(o_stall), 32'(sub));
      chk("req_mem_we", 32'(o_mem_we), 32'(we && !flt && !sub));
      if (!flt) chk("req_mem_addr", o_mem_addr, addr >> 2);
      if (we && !flt && !sub) chk("sw_wdata", o_mem_wdata, wdata);
      @(negedge clk);
      chk("fault", 32'(o_fault), 32'(flt));
      chk("rvalid", 32'(o_rvalid), 32'(ld));
      if (ld) chk("rdata", o_rdata, exp_rd);
      if (sub) begin
         chk("rmw_we", 32'(o_mem_we), 32'h1);
         chk("rmw_stall", 32'(o_stall), 32'h0);
         chk("rmw_addr", o_mem_addr, addr >> 2);
         chk("rmw_wdata", o_mem_wdata, exp_wr);
         @(negedge clk);
      end
      i_req = 1'b0;
      @(negedge clk);
      chk("after_we", 32'(o_mem_we), 32'h0);
      chk("after_rvalid", 32'(o_rvalid), 32'h0);
      chk("after_fault", 32'(o_fault), 32'h0);
   endtask

   initial begin
      // Reset state
      #2;
      chk("rst_rdata", o_rdata, 32'h0);
      chk("rst_rvalid", 32'(o_rvalid), 32'h0);
      chk("rst_fault", 32'(o_fault), 32'h0);
      chk("rst_stall", 32'(o_stall), 32'h0);
      chk("rst_mem_we", 32'(o_mem_we), 32'h0);
      @(negedge clk); @(negedge clk);
      i_rst = 1'b0;

      // Scenario 1: SW then LW
      run_op(1, 3'd2, 32'h08, 32'hDEADBEEF);
      chk("s1_mem2", mem[2], 32'hDEADBEEF);
      run_op(0, 3'd2, 32'h08, 32'h0);
      chk("s1_rdata", o_rdata, 32'hDEADBEEF);

      // Scenario 2: SB read-modify-write, then LBU/LB
      run_op(1, 3'd0, 32'h09, 32'h000000AA);
      chk("s2_mem2", mem[2], 32'hDEADAAEF);
      run_op(0, 3'd4, 32'h09, 32'h0);
      chk("s2_lbu", o_rdata, 32'h000000AA);
      run_op(0, 3'd0, 32'h09, 32'h0);
      chk("s2_lb", o_rdata, 32'hFFFFFFAA);

      // Scenario 3: halfword stores and loads
      run_op(1, 3'd1, 32'h0A, 32'h00001234);
      run_op(0, 3'd1, 32'h0A, 32'h0);
      chk("s3_lh", o_rdata, 32'h00001234);
      run_op(1, 3'd1, 32'h08, 32'h00008001);
      run_op(0, 3'd5, 32'h08, 32'h0);
      chk("s3_lhu", o_rdata, 32'h00008001);

      // Scenario 4: faulting requests leave memory untouched
      for (int i = 0; i < 32; i++) snap[i] = mem[i];
      run_op(0, 3'd2, 32'h06, 32'h0);
      run_op(1, 3'd1, 32'h05, 32'h5555);
      run_op(0, 3'd2, 32'h80, 32'h0);
      run_op(0, 3'd3, 32'h00, 32'h0);
      run_op(1, 3'd2, 32'h80, 32'h12345678);
      for (int i = 0; i < 32; i++) chk("s4_mem", mem[i], snap[i]);

      // Scenario 5: reset during the RMW write cycle drops the write
      run_op(1, 3'd2, 32'h04, 32'h11223344);
      @(negedge clk);
      i_req = 1'b1; i_we = 1'b1; i_funct3 = 3'd0; i_addr = 32'h04; i_wdata = 32'h000000AB;
      #1 chk("s5_stall", 32'(o_stall), 32'h1);
      @(negedge clk);
      i_rst = 1'b1;
      #1;
      chk("s5_rst_we", 32'(o_mem_we), 32'h0);
      chk("s5_rst_stall", 32'(o_stall), 32'h0);
      chk("s5_rst_rvalid", 32'(o_rvalid), 32'h0);
      chk("s5_rst_fault", 32'(o_fault), 32'h0);
      chk("s5_rst_rdata", o_rdata, 32'h0);
      @(negedge clk);
      i_rst = 1'b0; i_req = 1'b0;
      @(negedge clk);
      chk("s5_mem1", mem[1], 32'h11223344);
      run_op(0, 3'd2, 32'h04, 32'h0);

      // Random requests against the reference model
      for (int n = 0; n < 80; n++) begin
         logic [31:0] a;
         a = ($urandom % 8 == 0) ? $urandom : 32'($urandom_range(0, 135));
         run_op(bit'($urandom % 2), 3'($urandom % 8), a, $urandom);
      end
      for (int i = 0; i < 32; i++) chk("final_mem", mem[i], ref_mem[i]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
